clocked_xor_array: RTL and testbench
====================================

# clocked_xor_array

Parametrised, multi-channel successor to the single clocked XOR cell. Each channel collects toggle-encoded input events between evaluation strobes and, on a strobe, emits the selected logic function (XOR/OR/AND) of the events seen. The output is toggle-encoded, plus a level copy. The block sits between event-producing stimulus/DUT logic and VCD-checked timing assertions, and flags double-arrival violations per channel.

## Interface
- `N_CH`, 4, number of independent channels
- `N_IN`, 2, event inputs per channel (≥2)
- `clk` in 1, single clock; all state updates on rising edge
- `rst_n` in 1, synchronous, active-low reset
- `ev_in` in N_CH*N_IN, toggle-encoded events; bit `ch*N_IN+i` is input i of channel ch
- `eval` in 1, evaluation strobe (one-cycle pulse, shared by all channels)
- `op` in 2, function select: 0 XOR, 1 OR, 2 AND, 3 XNOR; sampled in the `eval` cycle
- `err_clr` in 1, clears `dbl_err` for all channels
- `out` out N_CH, toggle-encoded result; toggles when the channel result is 1
- `res` out N_CH, level result of the last evaluation
- `out_valid` out 1, one-cycle pulse, evaluation result registered
- `dbl_err` out N_CH, sticky: second event on the same input within one window

## Operation
- Event detection: `ev_q` registers `ev_in`. `tog = ev_in ^ ev_q`. A set bit is one event.
- Per input, an arrival flag `arr` is set on `tog`. It stays set until consumed by `eval`.
- Double arrival: `tog` on an input whose `arr` is already set.
  - `arr` stays 1, so pulses merge.
  - The channel's `dbl_err` bit is set.
- Evaluation, in a cycle with `eval` = 1, per channel:
  - `eff = arr | tog`. Events in the strobe cycle belong to the closing window.
  - XOR: odd parity of `eff` across N_IN. OR: any bit set. AND: all bits set. XNOR: inverted parity.
  - All `arr` bits are cleared in the same edge. Toggles in that cycle do not carry over.
- Output update, on the edge ending the `eval` cycle:
  - `res[ch]` gets the result.
  - `out[ch]` is inverted if the result is 1.
  - `out_valid` is 1 for that one cycle.
- `err_clr` clears `dbl_err`. If a double arrival happens in the same cycle, setting wins.
- With no `eval`, `arr` accumulates indefinitely. There is no timeout.

## Timing
- Reset, while `rst_n` = 0:
  - `ev_q` loads `ev_in`, so there is no spurious event at reset release.
  - `arr` = 0, `out` = 0, `res` = 0, `out_valid` = 0, `dbl_err` = 0.
  - Reset overrides `eval` and `err_clr`.
- Reset asserted mid-window: pending arrivals are discarded and nothing is emitted.
- Event-to-flag latency: 1 cycle. An `ev_in` change in cycle t sets `arr` at the edge ending t.
- Eval-to-output latency: 1 cycle. With `eval` in cycle t, `out`, `res` and `out_valid` are valid in t+1.
- `eval` in consecutive cycles is legal. Each evaluates its own window. An empty window yields XOR 0, OR 0, AND 0, XNOR 1.
- A toggle and a double-arrival on the same input in the `eval` cycle counts as one event and sets `dbl_err`.
- `op` is not registered. Only its value in the `eval` cycle matters.

## Configuration
- `CLOCKED_XOR_ERR_CNT_EN` defined:
  - Adds output `err_cnt` [N_CH*8], an 8-bit saturating count per channel of double-arrival events.
  - The count saturates at 255.
  - Cleared by reset and by `err_clr`. An increment in the same cycle as `err_clr` yields 1.
- `CLOCKED_XOR_ERR_CNT_EN` not defined: the port and counters do not exist. The sticky `dbl_err` is unaffected.

## Structure
- Package `clocked_logic_pkg` holds:
  - enum `op_t` (OP_XOR=0, OP_OR=1, OP_AND=2, OP_XNOR=3)
  - function `eval_op(op_t, logic [N_IN-1:0])`
  - constant `ERR_CNT_W = 8`
- Sub-module `clocked_logic_cell` implements one channel: arrival flags, detect, evaluate, output toggle, error logic.
- The top generates N_CH cells, shares `eval`, `op` and `err_clr`, and ORs per-cell valid into one `out_valid`. All cells are identical, so this equals any single cell's valid.

## Test plan
Bench parameters: N_CH=2, N_IN=2. Stimulus toggles `ev_in` bits.
- Reset release with `ev_in`=4'b1111 held: no `arr` set. A later `eval` gives `res`=0, `out`=0, `out_valid` pulse, `dbl_err`=0.
- XOR sequence, ch0: toggle a, later toggle b, then `eval` → `res[0]`=0, `out[0]` unchanged. Toggle a only, then `eval` → `res[0]`=1, `out[0]` 0→1, one cycle after `eval`.
- Modes, ch1 with both inputs toggled: `op`=1 → `res[1]`=1. `op`=2 → 1. `op`=0 → 0. Empty window with `op`=3 → 1.
- Simultaneous event, ch0: toggle b in the same cycle as `eval`, with a already arrived → XOR `res[0]`=0. The next empty `eval` gives `res[0]`=0, so the toggle did not carry over.
- Double arrival: toggle ch0 a twice before `eval` → `dbl_err`=2'b01 and XOR `res[0]`=1. `err_clr` → `dbl_err`=0. With macro: `err_cnt[7:0]`=1, and 300 double arrivals → 255.
- Reset mid-window: arrivals pending on both channels, `rst_n` low 1 cycle, then `eval` → `res`=2'b00, `out` unchanged from 0.

Source files
------------

// File: rtl/clocked_logic_pkg.sv
// Shared types and helpers for the clocked logic array: operation encoding,
// the per-channel evaluation function and the error-counter width.
package clocked_logic_pkg;

  typedef enum logic [1:0] {
    OP_XOR  = 2'd0,
    OP_OR   = 2'd1,
    OP_AND  = 2'd2,
    OP_XNOR = 2'd3
  } op_t;

  localparam int ERR_CNT_W = 8;
  localparam int MAX_IN    = 32;

  // Only the low n_in bits of eff take part; callers zero-pad the rest.
  function automatic logic eval_op(input op_t op, input logic [MAX_IN-1:0] eff,
                                   input int n_in);
    logic par;
    logic any;
    logic all;
    par = 1'b0;
    any = 1'b0;
    all = 1'b1;
    for (int i = 0; i < MAX_IN; i++) begin
      if (i < n_in) begin
        par = par ^ eff[i];
        any = any | eff[i];
        all = all & eff[i];
      end
    end
    case (op)
      OP_XOR:  return par;
      OP_OR:   return any;
      OP_AND:  return all;
      default: return ~par;
    endcase
  endfunction

endpackage

// File: rtl/clocked_logic_cell.sv
// One channel: toggle-event detection, arrival flags, evaluation on strobe,
// toggle-encoded output and double-arrival error (counter if CLOCKED_XOR_ERR_CNT_EN).
module clocked_logic_cell
  import clocked_logic_pkg::*;
#(
  parameter int N_IN = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_IN-1:0] ev_in,
  input  logic            eval,
  input  op_t             op,
  input  logic            err_clr,
  output logic            out,
  output logic            res,
  output logic            out_valid,
`ifdef CLOCKED_XOR_ERR_CNT_EN
  output logic [ERR_CNT_W-1:0] err_cnt,
`endif
  output logic            dbl_err
);

  logic [N_IN-1:0]   ev_q, ev_d;
  logic [N_IN-1:0]   arr_q, arr_d;
  logic [N_IN-1:0]   tog;
  logic [N_IN-1:0]   eff;
  logic [MAX_IN-1:0] eff_pad;
  logic              dbl_hit;
  logic              result;
  logic              out_q, out_d;
  logic              res_q, res_d;
  logic              vld_q, vld_d;
  logic              dbl_q, dbl_d;
`ifdef CLOCKED_XOR_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] cnt_q, cnt_d;
`endif

  always_comb begin
    ev_d    = ev_in;
    tog     = ev_in ^ ev_q;
    dbl_hit = |(tog & arr_q);
    // Toggles in the strobe cycle belong to the window being closed.
    eff     = arr_q | tog;
    eff_pad = '0;
    eff_pad[N_IN-1:0] = eff;
    result  = eval_op(op, eff_pad, N_IN);

    arr_d = eval ? '0 : eff;
    res_d = eval ? result : res_q;
    out_d = out_q ^ (eval & result);
    vld_d = eval;
    // A new double arrival wins over a simultaneous clear.
    dbl_d = dbl_hit ? 1'b1 : (err_clr ? 1'b0 : dbl_q);
`ifdef CLOCKED_XOR_ERR_CNT_EN
    cnt_d = cnt_q;
    if (err_clr)
      cnt_d = dbl_hit ? ERR_CNT_W'(1) : '0;
    else if (dbl_hit && (cnt_q != '1))
      cnt_d = cnt_q + ERR_CNT_W'(1);
`endif
  end

  // ev_q tracks ev_in in reset too, so releasing reset never creates an event.
  always_ff @(posedge clk) begin
    ev_q <= ev_d;
    if (!rst_n) begin
      arr_q <= '0;
      res_q <= 1'b0;
      out_q <= 1'b0;
      vld_q <= 1'b0;
      dbl_q <= 1'b0;
`ifdef CLOCKED_XOR_ERR_CNT_EN
      cnt_q <= '0;
`endif
    end else begin
      arr_q <= arr_d;
      res_q <= res_d;
      out_q <= out_d;
      vld_q <= vld_d;
      dbl_q <= dbl_d;
`ifdef CLOCKED_XOR_ERR_CNT_EN
      cnt_q <= cnt_d;
`endif
    end
  end

  assign out       = out_q;
  assign res       = res_q;
  assign out_valid = vld_q;
  assign dbl_err   = dbl_q;
`ifdef CLOCKED_XOR_ERR_CNT_EN
  assign err_cnt   = cnt_q;
`endif

endmodule

// File: rtl/clocked_xor_array.sv
// N_CH independent clocked logic cells sharing eval/op/err_clr.
// CLOCKED_XOR_ERR_CNT_EN adds per-channel 8-bit saturating err_cnt.
module clocked_xor_array
  import clocked_logic_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int N_IN = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_CH*N_IN-1:0] ev_in,
  input  logic                 eval,
  input  logic [1:0]           op,
  input  logic                 err_clr,
  output logic [N_CH-1:0]      out,
  output logic [N_CH-1:0]      res,
  output logic                 out_valid,
`ifdef CLOCKED_XOR_ERR_CNT_EN
  output logic [N_CH*ERR_CNT_W-1:0] err_cnt,
`endif
  output logic [N_CH-1:0]      dbl_err
);

  logic [N_CH-1:0] vld;
  op_t             op_e;

  assign op_e = op_t'(op);

  for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
    clocked_logic_cell #(.N_IN(N_IN)) u_cell (
      .clk      (clk),
      .rst_n    (rst_n),
      .ev_in    (ev_in[ch*N_IN +: N_IN]),
      .eval     (eval),
      .op       (op_e),
      .err_clr  (err_clr),
      .out      (out[ch]),
      .res      (res[ch]),
      .out_valid(vld[ch]),
`ifdef CLOCKED_XOR_ERR_CNT_EN
      .err_cnt  (err_cnt[ch*ERR_CNT_W +: ERR_CNT_W]),
`endif
      .dbl_err  (dbl_err[ch])
    );
  end

  // Every cell sees the same strobe, so the OR equals any single valid.
  assign out_valid = |vld;

endmodule

// File: tb/tb_clocked_xor_array.sv
// Scoreboard bench for clocked_xor_array (N_CH=2, N_IN=2): directed test-plan
// sequences followed by random toggles, checked against an event-count model.
module tb_clocked_xor_array;

  localparam int N_CH = 2;
  localparam int N_IN = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] ev_in;
  logic       eval;
  logic [1:0] op;
  logic       err_clr;
  logic [1:0] out;
  logic [1:0] res;
  logic       out_valid;
  logic [1:0] dbl_err;
`ifdef CLOCKED_XOR_ERR_CNT_EN
  logic [15:0] err_cnt;
`endif

  clocked_xor_array #(.N_CH(N_CH), .N_IN(N_IN)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ev_in    (ev_in),
    .eval     (eval),
    .op       (op),
    .err_clr  (err_clr),
    .out      (out),
    .res      (res),
    .out_valid(out_valid),
`ifdef CLOCKED_XOR_ERR_CNT_EN
    .err_cnt  (err_cnt),
`endif
    .dbl_err  (dbl_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [1:0] res;
    logic [1:0] out;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  // Reference model: number of events seen per input in the open window.
  int         cnt [2][2];
  int         mcnt[2];
  logic [1:0] mres, mout, mdbl;
  logic [3:0] mprev;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      mcnt[c] = 0;
      for (int i = 0; i < 2; i++) cnt[c][i] = 0;
    end
    mres  = '0;
    mout  = '0;
    mdbl  = '0;
    mprev = ev_in;
  endtask

  // Called at a falling edge: apply one cycle of stimulus, advance the model,
  // then check the sticky error state after the rising edge.
  task automatic step(input logic [3:0] tgl, input logic e, input logic [1:0] o,
                      input logic c);
    logic [3:0] tog;
    logic       hit;
    int         n_set;
    logic       r;
    exp_t       x;
    ev_in   = ev_in ^ tgl;
    eval    = e;
    op      = o;
    err_clr = c;
    tog     = ev_in ^ mprev;
    if (!rst_n) begin
      model_reset();
    end else begin
      mprev = ev_in;
      for (int ch = 0; ch < 2; ch++) begin
        hit = 1'b0;
        for (int i = 0; i < 2; i++) begin
          if (tog[ch*2+i]) begin
            if (cnt[ch][i] > 0) hit = 1'b1;
            cnt[ch][i]++;
          end
        end
        if (hit) mdbl[ch] = 1'b1;
        else if (c) mdbl[ch] = 1'b0;
        if (c) mcnt[ch] = hit ? 1 : 0;
        else if (hit && mcnt[ch] < 255) mcnt[ch]++;
        if (e) begin
          n_set = 0;
          for (int i = 0; i < 2; i++) if (cnt[ch][i] > 0) n_set++;
          case (o)
            2'd0:    r = (n_set % 2) == 1;
            2'd1:    r = n_set > 0;
            2'd2:    r = n_set == N_IN;
            default: r = (n_set % 2) == 0;
          endcase
          mres[ch] = r;
          if (r) mout[ch] = ~mout[ch];
          for (int i = 0; i < 2; i++) cnt[ch][i] = 0;
        end
      end
      if (e) begin
        x.cyc = cyc + 1;
        x.res = mres;
        x.out = mout;
        sb_q.push_back(x);
      end
    end
    @(posedge clk);
    @(negedge clk);
    chk("dbl_err", 32'(dbl_err), 32'(mdbl));
`ifdef CLOCKED_XOR_ERR_CNT_EN
    chk("err_cnt0", 32'(err_cnt[7:0]), 32'(mcnt[0]));
    chk("err_cnt1", 32'(err_cnt[15:8]), 32'(mcnt[1]));
`endif
    eval    = 1'b0;
    err_clr = 1'b0;
  endtask

  task automatic reset_cycle(input logic [3:0] tgl, input logic e);
    rst_n = 1'b0;
    step(tgl, e, 2'd0, 1'b1);
    chk("rst_out", 32'(out), 32'(0));
    chk("rst_res", 32'(res), 32'(0));
    chk("rst_dbl", 32'(dbl_err), 32'(0));
    rst_n = 1'b1;
  endtask

  // Monitor: every result must arrive exactly one cycle after its strobe.
  always @(negedge clk) begin
    if (cyc > 0) begin
      if (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
        mon_e = sb_q.pop_front();
        chk("out_valid", 32'(out_valid), 32'(1));
        chk("res", 32'(res), 32'(mon_e.res));
        chk("out", 32'(out), 32'(mon_e.out));
      end else begin
        chk("out_valid_idle", 32'(out_valid), 32'(0));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n   = 1'b0;
    ev_in   = 4'b1111;
    eval    = 1'b0;
    op      = 2'd0;
    err_clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out", 32'(out), 32'(0));
    chk("rst_res", 32'(res), 32'(0));
    chk("rst_valid", 32'(out_valid), 32'(0));
    chk("rst_dbl", 32'(dbl_err), 32'(0));
    rst_n = 1'b1;

    // ev_in held high through reset: the first window is empty.
    step(4'b0000, 1'b1, 2'd0, 1'b0);
    chk("empty_res", 32'(res), 32'(0));

    // XOR on ch0: a then b gives 0, a alone gives 1.
    step(4'b0001, 1'b0, 2'd0, 1'b0);
    step(4'b0000, 1'b0, 2'd0, 1'b0);
    step(4'b0010, 1'b0, 2'd0, 1'b0);
    step(4'b0000, 1'b1, 2'd0, 1'b0);
    step(4'b0001, 1'b0, 2'd0, 1'b0);
    step(4'b0000, 1'b1, 2'd0, 1'b0);
    chk("xor_a_only_res0", 32'(res[0]), 32'(1));
    chk("xor_a_only_out0", 32'(out[0]), 32'(1));

    // Function modes on ch1, then an empty XNOR window.
    step(4'b1100, 1'b0, 2'd0, 1'b0);
    step(4'b0000, 1'b1, 2'd1, 1'b0);
    step(4'b1100, 1'b0, 2'd0, 1'b0);
    step(4'b0000, 1'b1, 2'd2, 1'b0);
    step(4'b1100, 1'b0, 2'd0, 1'b0);
    step(4'b0000, 1'b1, 2'd0, 1'b0);
    step(4'b0000, 1'b1, 2'd3, 1'b0);
    chk("xnor_empty_res1", 32'(res[1]), 32'(1));

    // Toggle in the strobe cycle closes with the window and does not carry over.
    step(4'b0001, 1'b0, 2'd0, 1'b0);
    step(4'b0010, 1'b1, 2'd0, 1'b0);
    step(4'b0000, 1'b1, 2'd0, 1'b0);

    // Double arrival on ch0 input a.
    step(4'b0001, 1'b0, 2'd0, 1'b0);
    step(4'b0001, 1'b0, 2'd0, 1'b0);
    chk("dbl_set", 32'(dbl_err), 32'(2'b01));
`ifdef CLOCKED_XOR_ERR_CNT_EN
    chk("cnt_one", 32'(err_cnt[7:0]), 32'(1));
`endif
    step(4'b0000, 1'b1, 2'd0, 1'b0);
    chk("dbl_xor_res0", 32'(res[0]), 32'(1));
    step(4'b0000, 1'b0, 2'd0, 1'b1);
    chk("dbl_clr", 32'(dbl_err), 32'(0));

    // 300 double arrivals saturate the counter.
    for (int k = 0; k < 301; k++) step(4'b0001, 1'b0, 2'd0, 1'b0);
`ifdef CLOCKED_XOR_ERR_CNT_EN
    chk("cnt_sat", 32'(err_cnt[7:0]), 32'(255));
`endif
    step(4'b0000, 1'b1, 2'd0, 1'b1);

    // Reset mid-window discards pending arrivals.
    step(4'b0101, 1'b0, 2'd0, 1'b0);
    step(4'b1010, 1'b0, 2'd0, 1'b0);
    reset_cycle(4'b0000, 1'b0);
    step(4'b0000, 1'b1, 2'd0, 1'b0);
    chk("post_rst_res", 32'(res), 32'(0));
    chk("post_rst_out", 32'(out), 32'(0));

    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      logic [3:0] t;
      t = '0;
      for (int b = 0; b < 4; b++) t[b] = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 59) == 0)
        reset_cycle(t, 1'($urandom_range(0, 1)));
      else
        step(t, ($urandom_range(0, 2) == 0), 2'($urandom_range(0, 3)),
             ($urandom_range(0, 15) == 0));
    end

    step(4'b0000, 1'b0, 2'd0, 1'b0);
    step(4'b0000, 1'b0, 2'd0, 1'b0);
    chk("sb_drained", 32'(sb_q.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
